i2c_slave_responder: RTL and testbench

Synthesizable I2C target (slave) that answers the master-side transfers generated by the I2C AVIP master agent: it detects START/STOP, matches a 7-bit slave address, accepts a register address byte, then writes or returns data bytes from an internal register file. It sits on the shared SCL/SDA bus beside the slave agent and is the RTL end-point the master agent is checked against. All transfers are MSB-first, with 8-bit data and 8-bit register addresses.

---
 rtl/i2c_slave_responder_if.sv | 37 +++
 rtl/i2c_slave_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_responder_if.sv
// ---------------------------------------------------------------------------
// i2c_slave_responder_if : SCL/SDA pins plus register-write side channel
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface i2c_slave_responder_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_oe,
    output wr_strobe,
    output wr_addr,
    output wr_data,
    output busy
  );

  modport master (
    output scl_i,
    output sda_i,
    input  sda_oe,
    input  wr_strobe,
    input  wr_addr,
    input  wr_data,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// i2c_slave_responder : oversampling I2C target with a small register file.
// Optional feature macro: I2C_SLAVE_AUTO_INC_EN (register pointer auto-increment)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDRESS          = 7'b110_1000,
  parameter int         NO_OF_REG              = 4,
  parameter int         DATA_WIDTH             = 8,
  parameter int         REGISTER_ADDRESS_WIDTH = 8
) (
  input  logic                  pclk,
  input  logic                  areset,
  i2c_slave_responder_if.slave  bus
);

  localparam int PTR_W = (NO_OF_REG > 1) ? $clog2(NO_OF_REG) : 1;
  localparam logic [REGISTER_ADDRESS_WIDTH:0] REG_LIMIT =
    (REGISTER_ADDRESS_WIDTH + 1)'(NO_OF_REG);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_REG       = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  // [0],[1] synchronize, [2] is the previous synchronized level for edge detection
  logic [2:0] scl_pipe;
  logic [2:0] sda_pipe;

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      scl_pipe <= 3'b111;
      sda_pipe <= 3'b111;
    end else begin
      scl_pipe <= {scl_pipe[1:0], bus.scl_i};
      sda_pipe <= {sda_pipe[1:0], bus.sda_i};
    end
  end

  logic scl_high;
  logic start_det;
  logic stop_det;
  logic scl_rise;
  logic scl_fall;
  logic sda_bit;

  assign scl_high  = scl_pipe[1] & scl_pipe[2];
  assign start_det = scl_high & ~sda_pipe[1] &  sda_pipe[2];
  assign stop_det  = scl_high &  sda_pipe[1] & ~sda_pipe[2];
  assign scl_rise  =  scl_pipe[1] & ~scl_pipe[2];
  assign scl_fall  = ~scl_pipe[1] &  scl_pipe[2];
  assign sda_bit   = sda_pipe[1];

  state_t                  state;
  logic [2:0]              bit_cnt;
  logic [DATA_WIDTH-1:0]   shift;
  logic                    rw;
  logic [PTR_W-1:0]        ptr;
  logic [DATA_WIDTH-1:0]   regs [NO_OF_REG];
  logic                    oe;
  logic                    strobe;
  logic [7:0]              waddr;
  logic [7:0]              wdata;
  logic                    busy_q;

  logic [DATA_WIDTH-1:0]   shifted;
  logic                    byte_done;
  logic [PTR_W-1:0]        ptr_next;

  assign shifted   = {shift[DATA_WIDTH-2:0], sda_bit};
  assign byte_done = (bit_cnt == 3'd7);

`ifdef I2C_SLAVE_AUTO_INC_EN
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NO_OF_REG - 1);
  assign ptr_next = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
`else
  assign ptr_next = ptr;
`endif

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      rw      <= 1'b0;
      ptr     <= '0;
      oe      <= 1'b0;
      strobe  <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NO_OF_REG; i++) regs[i] <= '0;
    end else begin
      strobe <= 1'b0;
      // bus conditions take priority over any coincident SCL edge
      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        oe      <= 1'b0;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        oe      <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            busy_q <= 1'b0;
          end

          ST_ADDR: begin
            if (scl_rise) begin
              shift   <= shifted;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                if (shifted[DATA_WIDTH-1:1] == SLAVE_ADDRESS) begin
                  rw     <= shifted[0];
                  busy_q <= 1'b1;
                  state  <= ST_ADDR_ACK;
                end else begin
                  busy_q <= 1'b0;
                  state  <= ST_WAIT_STOP;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              oe <= 1'b1;
            end else if (scl_rise) begin
              bit_cnt <= '0;
              if (rw) begin
                shift <= regs[ptr];
                state <= ST_RDATA;
              end else begin
                state <= ST_REG;
              end
            end
          end

          ST_REG: begin
            if (scl_fall) begin
              oe <= 1'b0;
            end else if (scl_rise) begin
              shift   <= shifted;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                if ({1'b0, shifted} < REG_LIMIT) begin
                  ptr   <= shifted[PTR_W-1:0];
                  state <= ST_REG_ACK;
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end
            end
          end

          ST_REG_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              oe <= 1'b1;
            end else if (scl_rise) begin
              bit_cnt <= '0;
              state   <= ST_WDATA;
            end
          end

          ST_WDATA: begin
            if (scl_fall) begin
              oe <= 1'b0;
            end else if (scl_rise) begin
              shift   <= shifted;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                regs[ptr] <= shifted;
                strobe    <= 1'b1;
                waddr     <= 8'(ptr);
                wdata     <= 8'(shifted);
                ptr       <= ptr_next;
                state     <= ST_WDATA_ACK;
              end
            end
          end

          ST_RDATA: begin
            // open-drain: pulling low encodes a 0 bit
            if (scl_fall) begin
              oe    <= ~shift[DATA_WIDTH-1];
              shift <= {shift[DATA_WIDTH-2:0], 1'b0};
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) state <= ST_RDATA_ACK;
            end
          end

          ST_RDATA_ACK: begin
            if (scl_fall) begin
              oe <= 1'b0;
            end else if (scl_rise) begin
              bit_cnt <= '0;
              if (!sda_bit) begin
                ptr   <= ptr_next;
                shift <= regs[ptr_next];
                state <= ST_RDATA;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end

          ST_WAIT_STOP: begin
            if (scl_fall) oe <= 1'b0;
          end

          default: begin
            state <= ST_IDLE;
            oe    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe    = oe;
  assign bus.wr_strobe = strobe;
  assign bus.wr_addr   = waddr;
  assign bus.wr_data   = wdata;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_responder : directed I2C master transfers against the target.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_i2c_slave_responder;

  localparam time Q = 80;   // quarter SCL period, 8 pclk

  logic pclk;
  logic areset;
  logic scl_m;
  logic sda_m;
  logic sda_line;

  int total;
  int bad;
  int strobe_cnt;
  int oe_cnt;
  logic [7:0] last_addr;
  logic [7:0] last_data;

  i2c_slave_responder_if bus ();

  assign sda_line  = sda_m & ~bus.sda_oe;
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_line;

  i2c_slave_responder dut (
    .pclk   (pclk),
    .areset (areset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    strobe_cnt = 0;
    oe_cnt     = 0;
    last_addr  = '0;
    last_data  = '0;
  end

  always @(posedge pclk) begin
    if (bus.wr_strobe === 1'b1) begin
      strobe_cnt <= strobe_cnt + 1;
      last_addr  <= bus.wr_addr;
      last_data  <= bus.wr_data;
    end
    if (bus.sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put_bit(input logic b, output logic got);
    sda_m = b;
    #Q;
    scl_m = 1'b1;
    #Q;
    got = sda_line;
    #Q;
    scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    #Q;
    scl_m = 1'b1;
    #Q;
    sda_m = 1'b0;
    #Q;
    scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #Q;
    scl_m = 1'b1;
    #Q;
    sda_m = 1'b1;
    #(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) put_bit(b[i], dummy);
    put_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic [7:0] v;
    v = '0;
    for (int i = 7; i >= 0; i--) put_bit(1'b1, v[i]);
    b = v;
  endtask

  initial begin
    logic       ack;
    logic       dummy;
    logic [7:0] rd;
    int         s_strobe;
    int         s_oe;

    total  = 0;
    bad    = 0;
    scl_m  = 1'b1;
    sda_m  = 1'b1;
    areset = 1'b1;
    #40;
    check("rst_sda_oe",    bus.sda_oe,    0);
    check("rst_wr_strobe", bus.wr_strobe, 0);
    check("rst_wr_addr",   bus.wr_addr,   0);
    check("rst_wr_data",   bus.wr_data,   0);
    check("rst_busy",      bus.busy,      0);
    areset = 1'b0;
    #(2*Q);

    // address mismatch 0x4C+W
    s_strobe = strobe_cnt;
    s_oe     = oe_cnt;
    i2c_start();
    write_byte(8'h98, ack);
    check("mis_ack",    ack, 1);
    check("mis_oe",     oe_cnt - s_oe, 0);
    check("mis_busy",   bus.busy, 0);
    check("mis_strobe", strobe_cnt - s_strobe, 0);
    i2c_stop();

    // single write reg 2 <- 0xA5
    s_strobe = strobe_cnt;
    i2c_start();
    write_byte(8'hD0, ack);
    check("w1_addr_ack", ack, 0);
    check("w1_busy_mid", bus.busy, 1);
    write_byte(8'h02, ack);
    check("w1_reg_ack", ack, 0);
    write_byte(8'hA5, ack);
    check("w1_data_ack", ack, 0);
    check("w1_strobes", strobe_cnt - s_strobe, 1);
    check("w1_wr_addr", last_addr, 8'h02);
    check("w1_wr_data", last_data, 8'hA5);
    i2c_stop();
    check("w1_busy_after_stop", bus.busy, 0);

    // write 0x3C to reg 1, repeated START, read back with NACK
    i2c_start();
    write_byte(8'hD0, ack);
    check("wr_addr_ack", ack, 0);
    write_byte(8'h01, ack);
    check("wr_reg_ack", ack, 0);
    write_byte(8'h3C, ack);
    check("wr_data_ack", ack, 0);
    i2c_start();
    write_byte(8'hD1, ack);
    check("wr_rd_addr_ack", ack, 0);
    read_byte(rd);
    check("wr_rd_byte", rd, 8'h3C);
    check("wr_rd_release", bus.sda_oe, 0);
    put_bit(1'b1, dummy);
    i2c_stop();

    // burst write from reg 3, then burst read back
    s_strobe = strobe_cnt;
    i2c_start();
    write_byte(8'hD0, ack);
    check("bw_addr_ack", ack, 0);
    write_byte(8'h03, ack);
    check("bw_reg_ack", ack, 0);
    write_byte(8'h11, ack);
    check("bw_d0_ack", ack, 0);
    write_byte(8'h22, ack);
    check("bw_d1_ack", ack, 0);
    check("bw_strobes", strobe_cnt - s_strobe, 2);
`ifdef I2C_SLAVE_AUTO_INC_EN
    check("bw_last_addr", last_addr, 8'h00);
`else
    check("bw_last_addr", last_addr, 8'h03);
`endif
    check("bw_last_data", last_data, 8'h22);
    i2c_stop();
    i2c_start();
    write_byte(8'hD0, ack);
    write_byte(8'h03, ack);
    i2c_start();
    write_byte(8'hD1, ack);
    check("br_addr_ack", ack, 0);
    read_byte(rd);
`ifdef I2C_SLAVE_AUTO_INC_EN
    check("br_byte0_reg3", rd, 8'h11);
`else
    check("br_byte0_reg3", rd, 8'h22);
`endif
    put_bit(1'b0, dummy);
    read_byte(rd);
    check("br_byte1", rd, 8'h22);
    put_bit(1'b1, dummy);
    i2c_stop();

    // out-of-range register address
    s_strobe = strobe_cnt;
    i2c_start();
    write_byte(8'hD0, ack);
    check("oor_addr_ack", ack, 0);
    write_byte(8'h04, ack);
    check("oor_reg_nack", ack, 1);
    write_byte(8'h55, ack);
    check("oor_data_nack", ack, 1);
    check("oor_strobes", strobe_cnt - s_strobe, 0);
    i2c_stop();

    // asynchronous reset while the target drives a 0 data bit
    i2c_start();
    write_byte(8'hD0, ack);
    write_byte(8'h01, ack);
    i2c_start();
    write_byte(8'hD1, ack);
    check("ar_pre_ack", ack, 0);
    check("ar_driving_low", bus.sda_oe, 1);
    areset = 1'b1;
    #2;
    check("ar_oe_async", bus.sda_oe, 0);
    #20;
    areset = 1'b0;
    check("ar_busy", bus.busy, 0);
    check("ar_wr_addr", bus.wr_addr, 0);
    check("ar_wr_data", bus.wr_data, 0);
    i2c_start();
    write_byte(8'hD0, ack);
    check("ar_post_addr_ack", ack, 0);
    write_byte(8'h01, ack);
    check("ar_post_reg_ack", ack, 0);
    i2c_start();
    write_byte(8'hD1, ack);
    read_byte(rd);
    check("ar_reg1_cleared", rd, 8'h00);
    put_bit(1'b1, dummy);
    i2c_stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
